// File: rtl/gpio_io_regs.sv
// gpio_io_regs: bit-addressed memory-mapped GPIO/switch block.
// Each address selects one bit. Regions: OUT (R/W), IN (synchronised, RO),
// SW (debounced, RO), EVT (sticky rising-edge flags, W1C), MASK (R/W).
// Reads are registered. irq is the registered OR of the masked event flags.
module gpio_io_regs #(
   parameter int DATA_W  = 24,
   parameter int ADDR_W  = 8,
   parameter int N_OUT   = 36,
   parameter int N_IN    = 36,
   parameter int N_SW    = 4,
   parameter int DEB_CYC = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] dataIn,
   input  logic [N_SW-1:0]   switches,
   input  logic [N_IN-1:0]   gpio_in,
   output logic [N_OUT-1:0]  gpio_out,
   output logic [DATA_W-1:0] dataOut,
   output logic              rd_valid,
   output logic              irq
);

   localparam int NE        = N_IN + N_SW;
   localparam int OUT_BASE  = 0;
   localparam int IN_BASE   = OUT_BASE + N_OUT;
   localparam int SW_BASE   = IN_BASE + N_IN;
   localparam int EVT_BASE  = SW_BASE + N_SW;
   localparam int MASK_BASE = EVT_BASE + NE;
   localparam int TOP       = MASK_BASE + NE;
   localparam int CNT_W     = $clog2(DEB_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);

   // The address space must be able to reach every mapped bit.
   if ((2 ** ADDR_W) <= TOP) begin : g_addr_too_small
      $error("gpio_io_regs: ADDR_W too small for the address map");
   end

   logic [N_OUT-1:0]  r_out;
   logic [N_IN-1:0]   r_in_s1, r_in_s2, r_in_s3;
   logic [N_SW-1:0]   r_sw_s1, r_sw_s2;
   logic [N_SW-1:0]   r_deb;
   logic [CNT_W-1:0]  r_cnt [N_SW];
   logic [NE-1:0]     r_evt;
   logic [NE-1:0]     r_mask;
   logic [DATA_W-1:0] r_dout;
   logic              r_rd_valid;
   logic              r_irq;

   logic [31:0]       w_addr;
   logic [N_OUT-1:0]  w_out_hit;
   logic [N_IN-1:0]   w_in_hit;
   logic [N_SW-1:0]   w_sw_hit;
   logic [NE-1:0]     w_evt_hit;
   logic [NE-1:0]     w_mask_hit;
   logic [N_OUT-1:0]  w_out_we;
   logic [NE-1:0]     w_mask_we;
   logic [NE-1:0]     w_evt_clr;
   logic [NE-1:0]     w_evt_set;
   logic [N_IN-1:0]   w_in_rise;
   logic [N_SW-1:0]   w_deb_upd;
   logic [N_SW-1:0]   w_deb_rise;
   logic              w_rd_bit;
   logic              w_unused;

   assign w_addr   = 32'(address);
   // Only bit 0 of the write data carries information.
   assign w_unused = &{1'b0, dataIn[DATA_W-1:1]};

   // One-hot decode of the bit address into each region; out-of-map hits nothing.
   always_comb begin
      w_out_hit  = '0;
      w_in_hit   = '0;
      w_sw_hit   = '0;
      w_evt_hit  = '0;
      w_mask_hit = '0;
      for (int i = 0; i < N_OUT; i++) w_out_hit[i]  = (w_addr == 32'(OUT_BASE + i));
      for (int i = 0; i < N_IN; i++)  w_in_hit[i]   = (w_addr == 32'(IN_BASE + i));
      for (int i = 0; i < N_SW; i++)  w_sw_hit[i]   = (w_addr == 32'(SW_BASE + i));
      for (int i = 0; i < NE; i++)    w_evt_hit[i]  = (w_addr == 32'(EVT_BASE + i));
      for (int i = 0; i < NE; i++)    w_mask_hit[i] = (w_addr == 32'(MASK_BASE + i));
   end

   assign w_out_we  = w_out_hit  & {N_OUT{wr_en}};
   assign w_mask_we = w_mask_hit & {NE{wr_en}};
   assign w_evt_clr = w_evt_hit  & {NE{wr_en & dataIn[0]}};
   assign w_in_rise = r_in_s2 & ~r_in_s3;
   assign w_evt_set = {w_deb_rise, w_in_rise};

   // Read mux over the current (pre-write) register state.
   assign w_rd_bit = (|(r_out  & w_out_hit))
                   | (|(r_in_s2 & w_in_hit))
                   | (|(r_deb  & w_sw_hit))
                   | (|(r_evt  & w_evt_hit))
                   | (|(r_mask & w_mask_hit));

   // Debounce decision: commit s2 once it has disagreed with deb for DEB_CYC cycles.
   always_comb begin
      w_deb_upd  = '0;
      w_deb_rise = '0;
      for (int j = 0; j < N_SW; j++) begin
         if ((r_sw_s2[j] != r_deb[j]) && (r_cnt[j] == CNT_MAX)) begin
            w_deb_upd[j]  = 1'b1;
            w_deb_rise[j] = r_sw_s2[j];
         end else begin
            w_deb_upd[j]  = 1'b0;
            w_deb_rise[j] = 1'b0;
         end
      end
   end

   // Two-flop synchronisers plus a previous-value stage for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_s1 <= '0;
         r_in_s2 <= '0;
         r_in_s3 <= '0;
         r_sw_s1 <= '0;
         r_sw_s2 <= '0;
      end else begin
         r_in_s1 <= gpio_in;
         r_in_s2 <= r_in_s1;
         r_in_s3 <= r_in_s2;
         r_sw_s1 <= switches;
         r_sw_s2 <= r_sw_s1;
      end
   end

   // Per-switch stability counters and debounced values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_deb <= '0;
         for (int j = 0; j < N_SW; j++) r_cnt[j] <= '0;
      end else begin
         for (int j = 0; j < N_SW; j++) begin
            if (w_deb_upd[j]) begin
               r_deb[j] <= r_sw_s2[j];
               r_cnt[j] <= '0;
            end else if (r_sw_s2[j] != r_deb[j]) begin
               r_cnt[j] <= r_cnt[j] + CNT_W'(1);
            end else begin
               r_cnt[j] <= '0;
            end
         end
      end
   end

   // Software-visible OUT, MASK and sticky EVT registers; a set beats a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out  <= '0;
         r_mask <= '0;
         r_evt  <= '0;
      end else begin
         r_out  <= (r_out  & ~w_out_we)  | (w_out_we  & {N_OUT{dataIn[0]}});
         r_mask <= (r_mask & ~w_mask_we) | (w_mask_we & {NE{dataIn[0]}});
         r_evt  <= (r_evt  & ~w_evt_clr) | w_evt_set;
      end
   end

   // Registered read data, read-valid pulse and interrupt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout     <= '0;
         r_rd_valid <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         if (rd_en) begin
            r_dout <= {{(DATA_W-1){1'b0}}, w_rd_bit};
         end
         r_rd_valid <= rd_en;
         r_irq      <= |(r_evt & r_mask);
      end
   end

   assign gpio_out = r_out;
   assign dataOut  = r_dout;
   assign rd_valid = r_rd_valid;
   assign irq      = r_irq;

endmodule

// File: tb/tb_gpio_io_regs.sv
// Directed self-checking bench for gpio_io_regs with default parameters.
module tb_gpio_io_regs;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic        rd_en;
   logic [7:0]  address;
   logic [23:0] dataIn;
   logic [3:0]  switches;
   logic [35:0] gpio_in;
   logic [35:0] gpio_out;
   logic [23:0] dataOut;
   logic        rd_valid;
   logic        irq;

   int errors = 0;
   int checks = 0;

   gpio_io_regs dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .address  (address),
      .dataIn   (dataIn),
      .switches (switches),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .dataOut  (dataOut),
      .rd_valid (rd_valid),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [23:0] d);
      address = a;
      dataIn  = d;
      wr_en   = 1'b1;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic exp, input string tag);
      address = a;
      rd_en   = 1'b1;
      tick();
      rd_en   = 1'b0;
      chk(tag, 64'(dataOut), 64'(exp));
      chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
   endtask

   initial begin
      rst      = 1'b1;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      address  = 8'd0;
      dataIn   = 24'd0;
      switches = 4'd0;
      gpio_in  = 36'd0;
      tick();
      tick();
      chk("rst_gpio_out", 64'(gpio_out), 64'd0);
      chk("rst_dataOut",  64'(dataOut),  64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_irq",      64'(irq),      64'd0);
      rst = 1'b0;
      tick();

      // 1: single OUT bit write, ignored write to IN, registered read
      wr(8'd5, 24'd1);
      wr(8'd40, 24'h0FFFFE);
      chk("t1_gpio_out", 64'(gpio_out), 64'h20);
      rd(8'd5, 1'b1, "t1_rd5");
      tick();
      chk("t1_valid_drop", 64'(rd_valid), 64'd0);
      chk("t1_dout_hold",  64'(dataOut),  64'd1);
      rd(8'd6, 1'b0, "t1_rd6");

      // 2: gpio_in[3] rise -> sync, event, irq, W1C
      wr(8'd119, 24'd1);
      gpio_in[3] = 1'b1;
      tick();
      chk("t2_irq_e1", 64'(irq), 64'd0);
      rd(8'd39, 1'b0, "t2_in_e2");
      chk("t2_irq_e2", 64'(irq), 64'd0);
      rd(8'd39, 1'b1, "t2_in_e3");
      chk("t2_irq_e3", 64'(irq), 64'd0);
      tick();
      chk("t2_irq_e4", 64'(irq), 64'd1);
      rd(8'd79, 1'b1, "t2_evt_set");
      wr(8'd79, 24'd1);
      chk("t2_irq_hold", 64'(irq), 64'd1);
      tick();
      chk("t2_irq_clr", 64'(irq), 64'd0);
      rd(8'd79, 1'b0, "t2_evt_clr");

      // 3: switch 0 bounce shorter than the window, then a stable press
      switches[0] = 1'b1;
      repeat (10) tick();
      switches[0] = 1'b0;
      repeat (20) tick();
      rd(8'd72,  1'b0, "t3_bounce_sw");
      rd(8'd112, 1'b0, "t3_bounce_evt");
      switches[0] = 1'b1;
      repeat (17) tick();
      rd(8'd72,  1'b0, "t3_sw_edge17");
      rd(8'd72,  1'b1, "t3_sw_edge18");
      rd(8'd112, 1'b1, "t3_sw_evt");

      // 4: W1C in the same cycle as a new rising edge keeps the flag set
      gpio_in[3] = 1'b0;
      repeat (4) tick();
      rd(8'd79, 1'b0, "t4_evt_pre");
      gpio_in[3] = 1'b1;
      tick();
      tick();
      wr(8'd79, 24'd1);
      rd(8'd79, 1'b1, "t4_set_wins");

      // 5: top of map and out-of-map accesses
      wr(8'd155, 24'd1);
      rd(8'd155, 1'b1, "t5_rd155");
      rd(8'd156, 1'b0, "t5_rd156");
      rd(8'd255, 1'b0, "t5_rd255");
      wr(8'd156, 24'd1);
      wr(8'd255, 24'd1);
      wr(8'd50,  24'd1);
      chk("t5_gpio_out", 64'(gpio_out), 64'h20);
      rd(8'd50,  1'b0, "t5_rd50");
      rd(8'd0,   1'b0, "t5_rd0");
      rd(8'd155, 1'b1, "t5_rd155_again");
      rd(8'd156, 1'b0, "t5_rd156_again");

      // 6: asynchronous reset with everything active
      for (int i = 0; i < 36; i++) wr(8'(i), 24'd1);
      chk("t6_all_ones", 64'(gpio_out), 64'hF_FFFF_FFFF);
      chk("t6_irq_pre",  64'(irq),      64'd1);
      address = 8'd5;
      rd_en   = 1'b1;
      tick();
      chk("t6_valid_pre", 64'(rd_valid), 64'd1);
      gpio_in[0] = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      rd_en = 1'b0;
      chk("t6_async_gpio_out", 64'(gpio_out), 64'd0);
      chk("t6_async_dataOut",  64'(dataOut),  64'd0);
      chk("t6_async_rd_valid", 64'(rd_valid), 64'd0);
      chk("t6_async_irq",      64'(irq),      64'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      rd(8'd76,  1'b0, "t6_evt_e3");
      rd(8'd76,  1'b1, "t6_evt_e4");
      rd(8'd119, 1'b0, "t6_mask_clr");
      rd(8'd5,   1'b0, "t6_out_clr");
      chk("t6_irq_post", 64'(irq), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gpio_io_regs.md
Name: gpio_io_regs

Overview:
- Parametrised bit-addressed memory-mapped I/O block; successor to the fixed 76-bit switch/GPIO map.
- Generalises width, address and channel counts, registers the read path, and adds input synchronisers and switch debounce.
- Adds sticky rising-edge event flags with write-1-to-clear, per-channel interrupt masks and a registered irq output.
- Sits on the core's data-memory bus beside RAM; drives board GPIO header 2, samples header 1 and slide switches.

Parameters:
DATA_W, 24, bus data width; read data returned in bit 0, upper bits zero
ADDR_W, 8, bus address width; must satisfy 2^ADDR_W > TOP (elaboration error otherwise)
N_OUT, 36, output GPIO bits
N_IN, 36, input GPIO bits
N_SW, 4, switch inputs
DEB_CYC, 16, debounce stability window in clk cycles (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write strobe, one access per cycle
rd_en  in  1  read strobe
address  in  ADDR_W  bit address
dataIn  in  DATA_W  write data; only bit 0 used
switches  in  N_SW  raw asynchronous switches
gpio_in  in  N_IN  raw asynchronous GPIO inputs
gpio_out  out  N_OUT  output register
dataOut  out  DATA_W  registered read data
rd_valid  out  1  dataOut valid, one cycle after rd_en
irq  out  1  registered OR of (event & mask)

Behaviour:
- Address map (NE = N_IN+N_SW): OUT 0..N_OUT-1 (R/W); IN N_OUT..+N_IN-1 (RO, synchronised); SW next N_SW (RO, debounced); EVT next NE (R, W1C; index 0..N_IN-1 = gpio, then switches); MASK next NE (R/W); TOP = first unused address.
- Reset: gpio_out, dataOut, rd_valid, irq, all sync flops, debounced values, counters, EVT and MASK = 0.
- Sync: gpio_in and switches pass through 2 flops (s1, s2), then a prev flop s3.
- GPIO event: EVT[i] set on the cycle s2 & ~s3. Raw rise to sticky flag = 3 clk edges.
- Debounce per switch:
  - Counter increments while s2 != deb; otherwise clears.
  - When the counter reaches DEB_CYC-1 with s2 != deb: deb <= s2 and the counter clears.
  - A bounce shorter than DEB_CYC cycles never changes deb.
  - Rising deb sets the switch EVT bit the same cycle deb updates.
- Write (wr_en):
  - OUT/MASK bit <= dataIn[0].
  - EVT: dataIn[0]=1 clears the bit; 0 is a no-op.
  - IN/SW, address >= TOP: ignored.
- Set vs clear same cycle: set wins (flag stays 1).
- Read (rd_en): dataOut <= {0, bit} next edge; rd_valid pulses 1 cycle. Address >= TOP reads 0.
  - dataOut holds its value when rd_en=0.
  - Read and write in the same cycle to the same address returns the pre-write value.
- irq registered: irq(n+1) = |(EVT & MASK)(n). Deasserts one cycle after the last masked flag clears or its mask bit clears.
- gpio_out mirrors the OUT register directly (no extra latency after the write edge).
- Reset mid-operation clears everything immediately, including pending rd_valid.
- A high input at reset release produces an event (s3 resets to 0). Software clears EVT after init.

Test Plan:
1. Default params; write address 5 dataIn=1, then address 40 dataIn=0x0FFFFE -> gpio_out=0x20, no other effect; read 5 -> dataOut=1, rd_valid high exactly 1 cycle later.
2. gpio_in[3] 0->1 at cycle 0 -> read IN addr 39 returns 1 from cycle 2; EVT addr 76+3=79 sets at edge 3; MASK[3] (addr 119)=1 -> irq=1 one cycle later; write 1 to addr 79 -> irq=0 next cycle.
3. Switch 0 toggles 1 for 10 cycles then 0 (DEB_CYC=16) -> deb and EVT addr 112 stay 0. Held high 16+ cycles -> SW addr 72 reads 1 and EVT 112 sets.
4. W1C on EVT 79 in the same cycle a new rising edge of gpio_in[3] is detected -> EVT 79 remains 1.
5. Read addresses 155, 156, 255 -> 155 returns stored MASK bit; 156 and 255 return 0. Writes to 156/255 and to IN addr 50 change no state.
6. Assert rst while gpio_out=all ones, irq=1, rd_valid pending -> all outputs 0 asynchronously; after release with gpio_in[0]=1 held, EVT addr 76 sets 3 cycles later.
